// File: rtl/counter_mod.sv
// counter_mod: parametrised synchronous up/down modulo counter.
// The count range is 0..limit. The counter supports parallel load (clamped to limit),
// wrap-or-saturate at the bounds, and a registered one-cycle wrap pulse.
// Priority on each rising edge: reset > load > en > hold.
module counter_mod #(
    parameter int WIDTH = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] q,
    output logic             wrap,
    output logic             at_max,
    output logic             at_zero
);

    // Architectural state: the count and the wrap pulse. There is no other state.
    logic [WIDTH-1:0] r_q;
    logic             r_wrap;

    // Next-state values, and compares shared by the step logic and the status outputs.
    logic [WIDTH-1:0] w_q_next;
    logic             w_wrap_next;
    logic             w_ge_limit;
    logic             w_gt_limit;
    logic             w_is_zero;
    logic [WIDTH-1:0] w_load_clamped;

    assign w_ge_limit     = (r_q >= limit);
    assign w_gt_limit     = (r_q > limit);
    assign w_is_zero      = (r_q == '0);
    assign w_load_clamped = (load_val > limit) ? limit : load_val;

    // Next count and wrap pulse for load, enabled step and hold (reset is applied in the register)
    always_comb begin
        w_q_next    = r_q;
        w_wrap_next = 1'b0;
        if (load) begin
            w_q_next = w_load_clamped;
        end else if (en) begin
            if (up) begin
                if (!w_ge_limit) begin
                    // Cannot overflow: r_q < limit <= 2^WIDTH-1
                    w_q_next = r_q + WIDTH'(1);
                end else if (sat) begin
                    // Also pulls a count above a lowered limit back down to the limit
                    w_q_next = limit;
                end else begin
                    w_q_next    = '0;
                    w_wrap_next = 1'b1;
                end
            end else begin
                if (w_gt_limit) begin
                    // Limit was lowered under the count: snap to the top, no wrap
                    w_q_next = limit;
                end else if (!w_is_zero) begin
                    w_q_next = r_q - WIDTH'(1);
                end else if (!sat) begin
                    w_q_next    = limit;
                    w_wrap_next = 1'b1;
                end
                // At zero in saturate mode the count holds at zero
            end
        end
    end

    // State register with synchronous active-high reset
    always_ff @(posedge clock) begin
        if (reset) begin
            r_q    <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_q    <= w_q_next;
            r_wrap <= w_wrap_next;
        end
    end

    assign q       = r_q;
    assign wrap    = r_wrap;
    // Status flags are combinational from the registered count and the live limit
    assign at_max  = w_ge_limit;
    assign at_zero = w_is_zero;

endmodule

// File: doc/counter_mod.md
# counter_mod

Parametrised synchronous up/down modulo counter; the successor to the fixed 6-bit free-running counter. It adds run-time limit, direction, enable, parallel load, and wrap-or-saturate mode. It registers a one-cycle wrap pulse for timers, baud/tick generators and sequencers elsewhere in the design.

## Interface

**Parameters**
- WIDTH, 6: counter width in bits; legal range 1..32.

**Ports**
- clock  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-high reset; sampled on the rising edge of clock.
- en  in  1  count enable; one step per clock edge while high.
- up  in  1  direction: 1 = increment, 0 = decrement.
- sat  in  1  mode: 1 = saturate at the bounds, 0 = wrap modulo limit+1.
- load  in  1  parallel load strobe.
- load_val  in  WIDTH  value to load.
- limit  in  WIDTH  maximum count, inclusive; the count range is 0..limit.
- q  out  WIDTH  registered count.
- wrap  out  1  registered one-cycle pulse on a wrap event.
- at_max  out  1  combinational: q >= limit.
- at_zero  out  1  combinational: q == 0.

## Operation

**Priority on each rising edge:** reset > load > en > hold.

**Reset**
- q <= 0, wrap <= 0.
- Combinational outputs follow: at_zero = 1; at_max = 1 only if limit == 0.

**Load**
- q <= min(load_val, limit).
- wrap <= 0.
- en is ignored on this edge.

**Enabled step, up = 1**
- q < limit: q <= q + 1, wrap <= 0.
- q >= limit, sat = 0: q <= 0, wrap <= 1.
- q >= limit, sat = 1: q <= limit, wrap <= 0.

**Enabled step, up = 0**
- q > limit (limit lowered at run time): q <= limit, wrap <= 0, in either mode.
- 0 < q <= limit: q <= q - 1, wrap <= 0.
- q == 0, sat = 0: q <= limit, wrap <= 1.
- q == 0, sat = 1: q <= 0, wrap <= 0.

**Hold (en = 0, load = 0):** q unchanged, wrap <= 0.

**Arithmetic:** unsigned, WIDTH bits. No intermediate overflow is possible, because the increment only occurs when q < limit <= 2^WIDTH - 1.

**Boundary conditions**
- limit == 0, wrap mode, en held: q stays 0 and wrap is high on every enabled edge, in both directions.
- limit == 2^WIDTH - 1, up, wrap mode: full-range counter, identical in sequence to the original fixed counter when WIDTH = 6.
- up, sat, en, limit may change on any cycle and take effect on the next edge. There is no internal state other than q and wrap.
- reset asserted mid-count overrides load and en on the same edge.

## Timing

- Latency: q reflects a step, load or reset one clock after the edge on which it was sampled.
- wrap is asserted in the same cycle that q shows the wrapped value. It lasts exactly one cycle per wrap event.
- Back-to-back wrap events produce wrap high on consecutive cycles with no gap.
- at_max and at_zero are purely combinational from q and limit; there is no extra latency.
- Throughput: one step per clock.
- Single clock domain; no handshake.
- All inputs are assumed synchronous to clock.

## Test plan

1. **Reset and free-run.** WIDTH = 6, limit = 63, up = 1, sat = 0, en = 1 for 70 cycles after reset.
   - q counts 0..63, then 0..5.
   - wrap is high only in the cycle where q returns to 0.
   - at_max is high only while q = 63.
2. **Short modulus down, wrap.** limit = 9, load 3, then up = 0, en = 1.
   - q runs 3, 2, 1, 0, 9, 8, ...
   - wrap is high with the first 9.
3. **Saturate both directions.** limit = 5, sat = 1.
   - Counting up: q sticks at 5, wrap stays 0.
   - Switch to up = 0 for 7 cycles: q runs 4..0 and sticks at 0, wrap stays 0.
4. **Load clamp and priority.** limit = 10.
   - load_val = 20 with en = 1: q = 10 next cycle.
   - load and reset together: q = 0.
5. **Run-time limit change.** Counting up at q = 40, then set limit = 20.
   - Wrap mode: next edge q = 0, wrap = 1.
   - Repeat with up = 0: next edge q = 20, wrap = 0.
6. **Degenerate limit and hold.** limit = 0, wrap mode, en = 1.
   - q stays 0 and wrap is high every cycle.
   - Drop en: q holds and wrap goes low on the next cycle.
   - Run WIDTH = 1 with limit = 1: q toggles 0, 1, 0 with wrap on each return to 0.
